load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32-bit address/data.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 req_valid  in  1  core load/store request.
REQ-005 req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-011 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  out  1  valid with rsp_valid; misaligned or illegal funct3.
REQ-013 MemRead, MemWrite  out  1 each  data-memory strobes.
REQ-014 MemSize  out  3  000 byte, 001 half, 010 word.
REQ-015 A_Ram  out  32  memory byte address.
REQ-016 WriteData  out  32  memory store data.
REQ-017 ReadData  in  32  memory read data, valid the cycle after MemRead.

Function
REQ-018 SHALL use FSM states IDLE, ISSUE, LOAD_WAIT, STORE_HI; all memory outputs SHALL be registered.
REQ-019 SHALL capture the request on acceptance in cycle N.
REQ-020 SHALL treat as error: illegal funct3 (load 011/110/111; store other than 000/001/010), H/HU with addr[0]=1, W with addr[1:0]!=0; then no strobe, rsp_valid=1 and rsp_err=1 in N+1, and stay in IDLE.
REQ-021 Load: in N+1 (ISSUE) SHALL drive MemRead=1, MemSize=010, A_Ram={addr[31:2],2'b00}.
REQ-022 Load: in N+2 (LOAD_WAIT) SHALL sample ReadData, extract the lane selected by addr[1:0] and register it; rsp_valid=1 in N+3.
REQ-023 Extraction: B/BU use byte addr[1:0]; H/HU use bits [15:0] if addr[1]=0, else [31:16]; B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-024 SB: in N+1 SHALL drive MemWrite=1, MemSize=000, A_Ram=addr, WriteData={24'b0,wdata[7:0]}; rsp_valid in N+2.
REQ-025 SW: in N+1 SHALL drive MemWrite=1, MemSize=010, A_Ram=addr, WriteData=wdata; rsp_valid in N+2.
REQ-026 SH with addr[1:0]=00: one halfword write (MemSize=001, WriteData={16'b0,wdata[15:0]}); rsp_valid in N+2.
REQ-027 SH with addr[1:0]=10 SHALL be split: byte write to addr with wdata[7:0] in N+1, then STORE_HI byte write to addr+1 with wdata[15:8] in N+2; rsp_valid in N+3.
REQ-028 MemRead and MemWrite SHALL never be high together; each strobe is high for exactly one cycle per memory access; both are 0 in IDLE.
REQ-029 The FSM SHALL return to IDLE in the rsp_valid cycle, so req_ready=1 then and a back-to-back request may be accepted.
REQ-030 ReadData SHALL be ignored outside LOAD_WAIT.

Reset
REQ-031 When resetn=0 at an edge, the next cycle SHALL show state IDLE, req_ready=1, and all other outputs (strobes, MemSize, A_Ram, WriteData, rsp_*) at 0.
REQ-032 Reset mid-operation SHALL abort: no rsp_valid and no remaining STORE_HI write.

Structure
REQ-033 Package lsu_pkg SHALL hold the state enum, the funct3 constants and the MemSize constants (SZ_BYTE, SZ_HALF, SZ_WORD).
REQ-034 Lane select and extension SHALL be a combinational sub-module, load_extend.

Verification (memory word 0x100 preloaded 0x8765F0A1)
REQ-035 LB 0x101 -> MemRead, A_Ram=0x100 in N+1; rsp_rdata=0xFFFFFFF0 in N+3; LBU -> 0x000000F0.
REQ-036 LH 0x102 -> 0xFFFF8765; LHU 0x102 -> 0x00008765; LW 0x100 -> 0x8765F0A1.
REQ-037 SH 0x102 wdata 0x0000BEEF -> byte EF at 0x102 (N+1), BE at 0x103 (N+2), rsp N+3; then LW 0x100 -> 0xBEEFF0A1.
REQ-038 SW 0x106, LH 0x101, load funct3=011 -> rsp_err=1 in N+1, no strobe.
REQ-039 SB 0x100 data 0x55, LW 0x100 accepted in the rsp cycle -> 0x8765F055.
REQ-040 resetn=0 during LOAD_WAIT or STORE_HI -> all outputs 0 next cycle, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state, width-code and memory-size definitions for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        LOAD_WAIT = 2'd2,
        STORE_HI  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    // Unsigned codes only exist for loads; halfwords need even, words 4-aligned addresses.
    function automatic logic req_is_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (f3)
            F3_B:    err = 1'b0;
            F3_BU:   err = we;
            F3_H:    err = off[0];
            F3_HU:   err = we | off[0];
            F3_W:    err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed lane of a loaded word and sign/zero-extends it
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_byte_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store sequencer between a core request port and a word data memory
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  MemSize,
    output logic [31:0] A_Ram,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nx;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [7:0]  r_wdata_hi;

    logic        r_mem_read,   w_mem_read_nx;
    logic        r_mem_write,  w_mem_write_nx;
    logic [2:0]  r_mem_size,   w_mem_size_nx;
    logic [31:0] r_a_ram,      w_a_ram_nx;
    logic [31:0] r_write_data, w_write_data_nx;
    logic        r_rsp_valid,  w_rsp_valid_nx;
    logic        r_rsp_err,    w_rsp_err_nx;
    logic [31:0] r_rsp_rdata,  w_rsp_rdata_nx;

    logic        w_accept;
    logic [31:0] w_load_data;

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

    load_extend u_load_extend (
        .i_rdata    (ReadData),
        .i_funct3   (r_funct3),
        .i_byte_off (r_addr[1:0]),
        .o_data     (w_load_data)
    );

    always_comb begin
        w_state_nx      = r_state;
        w_mem_read_nx   = 1'b0;
        w_mem_write_nx  = 1'b0;
        w_mem_size_nx   = SZ_BYTE;
        w_a_ram_nx      = 32'h0;
        w_write_data_nx = 32'h0;
        w_rsp_valid_nx  = 1'b0;
        w_rsp_err_nx    = 1'b0;
        w_rsp_rdata_nx  = 32'h0;

        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (req_is_err(req_we, req_funct3, req_addr[1:0])) begin
                        w_rsp_valid_nx = 1'b1;
                        w_rsp_err_nx   = 1'b1;
                    end else if (!req_we) begin
                        w_state_nx    = ISSUE;
                        w_mem_read_nx = 1'b1;
                        w_mem_size_nx = SZ_WORD;
                        w_a_ram_nx    = {req_addr[31:2], 2'b00};
                    end else begin
                        w_state_nx     = ISSUE;
                        w_mem_write_nx = 1'b1;
                        w_a_ram_nx     = req_addr;
                        case (req_funct3)
                            F3_H: begin
                                // An upper-half store is split so each write stays within the byte lanes the memory accepts.
                                if (req_addr[1]) begin
                                    w_mem_size_nx   = SZ_BYTE;
                                    w_write_data_nx = {24'h0, req_wdata[7:0]};
                                end else begin
                                    w_mem_size_nx   = SZ_HALF;
                                    w_write_data_nx = {16'h0, req_wdata[15:0]};
                                end
                            end
                            F3_W: begin
                                w_mem_size_nx   = SZ_WORD;
                                w_write_data_nx = req_wdata;
                            end
                            default: begin
                                w_mem_size_nx   = SZ_BYTE;
                                w_write_data_nx = {24'h0, req_wdata[7:0]};
                            end
                        endcase
                    end
                end
            end
            ISSUE: begin
                if (!r_we) begin
                    w_state_nx = LOAD_WAIT;
                end else if (r_funct3 == F3_H && r_addr[1]) begin
                    w_state_nx      = STORE_HI;
                    w_mem_write_nx  = 1'b1;
                    w_mem_size_nx   = SZ_BYTE;
                    w_a_ram_nx      = r_addr + 32'd1;
                    w_write_data_nx = {24'h0, r_wdata_hi};
                end else begin
                    w_state_nx     = IDLE;
                    w_rsp_valid_nx = 1'b1;
                end
            end
            LOAD_WAIT: begin
                w_state_nx     = IDLE;
                w_rsp_valid_nx = 1'b1;
                w_rsp_rdata_nx = w_load_data;
            end
            STORE_HI: begin
                w_state_nx     = IDLE;
                w_rsp_valid_nx = 1'b1;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_size   <= SZ_BYTE;
            r_a_ram      <= 32'h0;
            r_write_data <= 32'h0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= 32'h0;
        end else begin
            r_state      <= w_state_nx;
            r_mem_read   <= w_mem_read_nx;
            r_mem_write  <= w_mem_write_nx;
            r_mem_size   <= w_mem_size_nx;
            r_a_ram      <= w_a_ram_nx;
            r_write_data <= w_write_data_nx;
            r_rsp_valid  <= w_rsp_valid_nx;
            r_rsp_err    <= w_rsp_err_nx;
            r_rsp_rdata  <= w_rsp_rdata_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_we       <= 1'b0;
            r_funct3   <= F3_B;
            r_addr     <= 32'h0;
            r_wdata_hi <= 8'h0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_wdata_hi <= req_wdata[15:8];
        end
    end

    assign MemRead   = r_mem_read;
    assign MemWrite  = r_mem_write;
    assign MemSize   = r_mem_size;
    assign A_Ram     = r_a_ram;
    assign WriteData = r_write_data;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] ReadData = 32'h0;
    logic        req_ready, rsp_valid, rsp_err, MemRead, MemWrite;
    logic [31:0] rsp_rdata, A_Ram, WriteData;
    logic [2:0]  MemSize;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
        .A_Ram(A_Ram), .WriteData(WriteData), .ReadData(ReadData)
    );

    // Expected observable outputs per cycle, filled in when the model accepts a request.
    typedef struct packed {
        logic        busy;
        logic        rd;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic        rerr;
        logic [31:0] rdata;
        logic        strict;
    } sched_t;

    localparam int MAXC = 8192;
    sched_t sched [MAXC];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int model_free = 0;

    logic [7:0]  model_mem [int];
    logic [7:0]  ram_mem   [int];
    logic        rd_pending = 1'b0;
    int          rd_addr = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    function automatic logic [7:0] init_byte(input int a);
        logic [31:0] w;
        w = 32'h8765F0A1;
        if (a >= 32'h100 && a < 32'h104) return w[8*(a-32'h100) +: 8];
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [7:0] mbyte(input int a);
        return model_mem.exists(a) ? model_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rbyte(input int a);
        return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input int a);
        logic [7:0] b0, b1, b2, b3;
        b0 = mbyte(a); b1 = mbyte(a + 1); b2 = mbyte(a + 2); b3 = mbyte(a + 3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    task automatic model_accept(input int n, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d);
        logic legal, err;
        int   nbytes;
        if (n + 4 >= MAXC) begin
            $display("FAIL sched_overflow cyc=%0d actual=%0d required<%0d", cyc, n, MAXC - 4);
            n_err++;
            $fatal(1, "schedule overflow");
        end
        legal  = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err    = !legal || ((a % nbytes) != 0);
        if (err) begin
            sched[n+1].rv   = 1'b1;
            sched[n+1].rerr = 1'b1;
            model_free = n + 1;
        end else if (!we) begin
            sched[n+1].busy = 1'b1; sched[n+1].rd = 1'b1; sched[n+1].sz = 3'd2;
            sched[n+1].addr = a & ~32'd3;
            sched[n+2].busy = 1'b1;
            sched[n+3].rv   = 1'b1;
            sched[n+3].rdata = mdl_load(f3, int'(a));
            model_free = n + 3;
        end else begin
            for (int i = 0; i < nbytes; i++) model_mem[int'(a) + i] = d[8*i +: 8];
            if (nbytes == 2 && (a % 4) == 2) begin
                sched[n+1].busy = 1'b1; sched[n+1].wr = 1'b1; sched[n+1].sz = 3'd0;
                sched[n+1].addr = a;     sched[n+1].wdata = {24'h0, d[7:0]};
                sched[n+2].busy = 1'b1; sched[n+2].wr = 1'b1; sched[n+2].sz = 3'd0;
                sched[n+2].addr = a + 1; sched[n+2].wdata = {24'h0, d[15:8]};
                sched[n+3].rv   = 1'b1;
                model_free = n + 3;
            end else begin
                sched[n+1].busy = 1'b1; sched[n+1].wr = 1'b1;
                sched[n+1].sz   = (nbytes == 1) ? 3'd0 : (nbytes == 2) ? 3'd1 : 3'd2;
                sched[n+1].addr = a;
                sched[n+1].wdata = (nbytes == 1) ? {24'h0, d[7:0]} : (nbytes == 2) ? {16'h0, d[15:0]} : d;
                sched[n+2].rv   = 1'b1;
                model_free = n + 2;
            end
        end
    endtask

    task automatic model_reset(input int k);
        for (int i = k; i < k + 8; i++) sched[i] = '0;
        sched[k].strict = 1'b1;
        model_free = k;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle_cycle();
        if (cyc < model_free) begin
            req_valid  = 1'($urandom % 2);
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        step();
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        while (cyc < model_free) drive_idle_cycle();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        model_accept(cyc, we, f3, a, d);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        while (cyc <= model_free) drive_idle_cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory device: answers a read with the word one cycle later, garbage otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_pending) begin
                ReadData = {rbyte(rd_addr + 3), rbyte(rd_addr + 2), rbyte(rd_addr + 1), rbyte(rd_addr)};
                rd_pending = 1'b0;
            end else begin
                ReadData = $urandom;
            end
        end
    end

    initial begin
        sched_t e;
        int     a;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < MAXC) begin
                e = sched[cyc];
                chk("req_ready", req_ready, !e.busy);
                chk("MemRead", MemRead, e.rd);
                chk("MemWrite", MemWrite, e.wr);
                chk("strobe_excl", MemRead & MemWrite, 0);
                if (e.rd || e.wr) begin
                    chk("MemSize", MemSize, e.sz);
                    chk("A_Ram", A_Ram, e.addr);
                end
                if (e.wr) chk("WriteData", WriteData, e.wdata);
                chk("rsp_valid", rsp_valid, e.rv);
                if (e.rv) begin
                    chk("rsp_err", rsp_err, e.rerr);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
                if (e.strict) begin
                    chk("rst_MemSize", MemSize, 0);
                    chk("rst_A_Ram", A_Ram, 0);
                    chk("rst_WriteData", WriteData, 0);
                    chk("rst_rsp_err", rsp_err, 0);
                    chk("rst_rsp_rdata", rsp_rdata, 0);
                end
                if (MemWrite === 1'b1) begin
                    a = int'(A_Ram);
                    ram_mem[a] = WriteData[7:0];
                    if (MemSize != 3'd0) ram_mem[a + 1] = WriteData[15:8];
                    if (MemSize == 3'd2) begin
                        ram_mem[a + 2] = WriteData[23:16];
                        ram_mem[a + 3] = WriteData[31:24];
                    end
                end
                if (MemRead === 1'b1) begin
                    rd_pending = 1'b1;
                    rd_addr    = int'(A_Ram);
                end
                if (rsp_valid === 1'b1) begin
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                end
            end
        end
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < MAXC; i++) sched[i] = '0;
        for (int i = 1; i <= 3; i++) sched[i].strict = 1'b1;
        model_free = 3;
        step(); step(); step();
        resetn = 1'b1;

        issue(0, 3'b000, 32'h101, 0); wait_done(); chk("LB_0x101", last_rdata, 32'hFFFFFFF0);
        issue(0, 3'b100, 32'h101, 0); wait_done(); chk("LBU_0x101", last_rdata, 32'h000000F0);
        issue(0, 3'b001, 32'h102, 0); wait_done(); chk("LH_0x102", last_rdata, 32'hFFFF8765);
        issue(0, 3'b101, 32'h102, 0); wait_done(); chk("LHU_0x102", last_rdata, 32'h00008765);
        issue(0, 3'b010, 32'h100, 0); wait_done(); chk("LW_0x100", last_rdata, 32'h8765F0A1);

        issue(1, 3'b001, 32'h102, 32'h0000BEEF); wait_done();
        chk("SH_split_lo", rbyte(32'h102), 32'hEF);
        chk("SH_split_hi", rbyte(32'h103), 32'hBE);
        issue(0, 3'b010, 32'h100, 0); wait_done(); chk("LW_after_SH", last_rdata, 32'hBEEFF0A1);

        issue(1, 3'b010, 32'h106, 32'h12345678); wait_done(); chk("SW_0x106_err", last_err, 1);
        issue(0, 3'b010, 32'h100, 0); wait_done(); chk("LW_clears_err", last_err, 0);
        issue(0, 3'b001, 32'h101, 0); wait_done(); chk("LH_0x101_err", last_err, 1);
        issue(0, 3'b011, 32'h100, 0); wait_done(); chk("LD_f3_011_err", last_err, 1);

        issue(1, 3'b001, 32'h102, 32'h00008765); wait_done();
        issue(1, 3'b000, 32'h100, 32'h00000055);
        issue(0, 3'b010, 32'h100, 0); wait_done(); chk("SB_then_LW", last_rdata, 32'h8765F055);

        issue(0, 3'b010, 32'h204, 0);
        step();
        resetn = 1'b0; model_reset(cyc + 1); step(); resetn = 1'b1;
        issue(1, 3'b001, 32'h206, 32'h00001234);
        step();
        resetn = 1'b0; model_reset(cyc + 1); step(); resetn = 1'b1;
        issue(1, 3'b001, 32'h20A, 32'h00005678);
        resetn = 1'b0; model_reset(cyc + 1); step(); resetn = 1'b1;
        step();
        chk("abort_no_hi_write", ram_mem.exists(32'h20B), 0);
        chk("abort_lo_written", rbyte(32'h20A), 32'h78);

        for (int t = 0; t < 600; t++) begin
            if ($urandom % 4 == 0) drive_idle_cycle();
            we = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            a  = 32'h100 + ($urandom % 64);
            if ($urandom % 3 != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                else if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            issue(we, f3, a, $urandom);
        end
        wait_done();
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
